// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 mode constants, FSM states and coordinate type
package vga_timing_pkg;

  localparam int MODE_H_TOTAL  = 800;
  localparam int MODE_V_TOTAL  = 521;
  localparam int MODE_H_PULSE  = 96;
  localparam int MODE_V_PULSE  = 2;
  localparam int MODE_HBP      = 144;
  localparam int MODE_VBP      = 31;
  localparam int MODE_H_ACTIVE = 640;
  localparam int MODE_V_ACTIVE = 480;

  localparam int CNT_W     = 10;
  localparam int TMO_LIMIT = 1024;

  typedef logic [CNT_W-1:0] coord_t;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  function automatic coord_t sat_inc(input coord_t v);
    return (v == '1) ? v : coord_t'(v + 1'b1);
  endfunction

endpackage

// File: rtl/vga_timing_decoder_if.sv
// rtl/vga_timing_decoder_if.sv - sync input and recovered-timing bundle
interface vga_timing_decoder_if;
  import vga_timing_pkg::*;

  logic   pix_ce;
  logic   hsync_in;
  logic   vsync_in;
  coord_t x;
  coord_t y;
  logic   de;
  logic   locked;
  logic   lock_err;
  coord_t h_total;
  coord_t v_total;
  coord_t h_pulse;
  coord_t v_pulse;

  modport master (
    output pix_ce, hsync_in, vsync_in,
    input  x, y, de, locked, lock_err, h_total, v_total, h_pulse, v_pulse
  );

  modport slave (
    input  pix_ce, hsync_in, vsync_in,
    output x, y, de, locked, lock_err, h_total, v_total, h_pulse, v_pulse
  );

endinterface

// File: rtl/sync_pulse_meter.sv
// rtl/sync_pulse_meter.sv - active-low sync edge detect, period and low-width measurement
module sync_pulse_meter
  import vga_timing_pkg::*;
#(
  parameter int EXP_TOTAL = MODE_H_TOTAL,
  parameter int EXP_PULSE = MODE_H_PULSE
) (
  input  logic   clk,
  input  logic   clr,
  input  logic   en,
  input  logic   sync_in,
  output logic   fall,
  output logic   bad,
  output coord_t cnt,
  output coord_t total,
  output coord_t pulse
);

  logic   q;
  logic   rise;
  coord_t width;

  assign fall = en & q & ~sync_in;
  assign rise = en & ~q & sync_in;
  // The fall sample closes a period; the rise sample closes a pulse.
  assign bad  = (fall & (sat_inc(cnt) != coord_t'(EXP_TOTAL)))
              | (rise & (width != coord_t'(EXP_PULSE)));

  always_ff @(posedge clk) begin
    if (clr) begin
      q     <= 1'b1;
      cnt   <= '0;
      width <= '0;
      total <= '0;
      pulse <= '0;
    end else if (en) begin
      q <= sync_in;
      if (fall) begin
        cnt   <= '0;
        total <= sat_inc(cnt);
        width <= coord_t'(1);
      end else begin
        cnt <= sat_inc(cnt);
        if (!sync_in) width <= sat_inc(width);
      end
      if (rise) pulse <= width;
    end
  end

endmodule

// File: rtl/vga_timing_decoder.sv
// rtl/vga_timing_decoder.sv - measures incoming sync timing, locks to the mode, recovers x/y/de
module vga_timing_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = MODE_H_TOTAL,
  parameter int V_TOTAL     = MODE_V_TOTAL,
  parameter int H_PULSE     = MODE_H_PULSE,
  parameter int V_PULSE     = MODE_V_PULSE,
  parameter int HBP         = MODE_HBP,
  parameter int VBP         = MODE_VBP,
  parameter int H_ACTIVE    = MODE_H_ACTIVE,
  parameter int V_ACTIVE    = MODE_V_ACTIVE,
  parameter int LOCK_FRAMES = 3
) (
  input logic                 clk,
  input logic                 clr,
  vga_timing_decoder_if.slave bus
);

  coord_t      rh, rv, h_tot, v_tot, h_pul, v_pul;
  logic        h_fall, h_bad, frame_start, v_bad;
  state_t      state;
  logic [3:0]  good_cnt;
  logic        locked, lock_err, frame_bad;
  logic [10:0] tmo;
  logic        tmo_hit, frame_good, in_h, in_v, de;

  sync_pulse_meter #(.EXP_TOTAL(H_TOTAL), .EXP_PULSE(H_PULSE)) u_hmeter (
    .clk(clk), .clr(clr), .en(bus.pix_ce), .sync_in(bus.hsync_in),
    .fall(h_fall), .bad(h_bad), .cnt(rh), .total(h_tot), .pulse(h_pul)
  );

  // Vertical meter runs in line units: it only advances on hsync falls.
  sync_pulse_meter #(.EXP_TOTAL(V_TOTAL), .EXP_PULSE(V_PULSE)) u_vmeter (
    .clk(clk), .clr(clr), .en(h_fall), .sync_in(bus.vsync_in),
    .fall(frame_start), .bad(v_bad), .cnt(rv), .total(v_tot), .pulse(v_pul)
  );

  assign tmo_hit    = bus.pix_ce & ~h_fall & (tmo == 11'(TMO_LIMIT - 1));
  // Includes the line (and frame length) closing on this very sample.
  assign frame_good = ~(frame_bad | h_bad | v_bad);

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= SEARCH;
      good_cnt  <= '0;
      locked    <= 1'b0;
      lock_err  <= 1'b0;
      frame_bad <= 1'b0;
      tmo       <= '0;
    end else begin
      lock_err <= 1'b0;
      if (bus.pix_ce) begin
        if (h_fall)                        tmo <= '0;
        else if (tmo != 11'(TMO_LIMIT))    tmo <= tmo + 11'd1;

        if (frame_start)                   frame_bad <= 1'b0;
        else if (h_bad | v_bad)            frame_bad <= 1'b1;

        if (tmo_hit) begin
          state    <= SEARCH;
          locked   <= 1'b0;
          good_cnt <= '0;
          lock_err <= (state == LOCKED);
        end else if (frame_start) begin
          case (state)
            SEARCH: begin
              state    <= TRACK;
              good_cnt <= '0;
            end
            TRACK: begin
              if (!frame_good) begin
                good_cnt <= '0;
              end else if (good_cnt + 4'd1 == 4'(LOCK_FRAMES)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + 4'd1;
              end
            end
            LOCKED: begin
              if (!frame_good) begin
                state    <= TRACK;
                locked   <= 1'b0;
                good_cnt <= '0;
                lock_err <= 1'b1;
              end
            end
            default: state <= SEARCH;
          endcase
        end
      end
    end
  end

  assign in_h = (rh >= coord_t'(HBP)) && (rh < coord_t'(HBP + H_ACTIVE));
  assign in_v = (rv >= coord_t'(VBP)) && (rv < coord_t'(VBP + V_ACTIVE));
  assign de   = locked & in_h & in_v;

  assign bus.de       = de;
  assign bus.x        = de ? coord_t'(rh - coord_t'(HBP)) : '0;
  assign bus.y        = de ? coord_t'(rv - coord_t'(VBP)) : '0;
  assign bus.locked   = locked;
  assign bus.lock_err = lock_err;
  assign bus.h_total  = h_tot;
  assign bus.v_total  = v_tot;
  assign bus.h_pulse  = h_pul;
  assign bus.v_pulse  = v_pul;

endmodule
